lc3_mem_ctrl: RTL and testbench
===============================

LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the number of RAM word-address bits (2^ADDR_W x 16-bit words).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 3 (legal 1..15), giving the access latency in clk cycles.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset: clk input 1 (all state on its rising edge), and rst input 1 (asynchronous, active-high reset).
REQ-004 The block SHALL have i_ld_mar input 1: load MAR from i_bus.
REQ-005 The block SHALL have i_ld_mdr input 1: load MDR.
REQ-006 The block SHALL have i_mio_en input 1: memory access request, held by the sequencer until o_ready.
REQ-007 The block SHALL have i_r_w input 1: 1 = write, 0 = read; sampled at access start.
REQ-008 The block SHALL have i_bus input 16: CPU bus.
REQ-009 The block SHALL have i_sw input 4: switch/display-select value.
REQ-010 The block SHALL have o_mdr output 16: MDR contents, driven toward GateMDR.
REQ-011 The block SHALL have o_mar output 16: MAR contents, for the display mux.
REQ-012 The block SHALL have o_ready output 1: access complete.
REQ-013 The block SHALL have o_io_reg output 16: memory-mapped output register.

Function
REQ-014 The FSM SHALL have three states, IDLE, BUSY and DONE; IDLE is the reset state.
REQ-015 In IDLE, with i_mio_en=1, the block SHALL latch i_r_w and load the wait counter with WAIT_CYCLES-1, then go to BUSY.
REQ-016 In BUSY, the counter SHALL decrement each cycle; at counter==0 the access SHALL execute and the state SHALL become DONE.
REQ-017 Access execution SHALL be as follows:
- Read: the read-data register <= RAM[MAR[ADDR_W-1:0]].
- Write: RAM[MAR[ADDR_W-1:0]] <= MDR.
REQ-018 o_ready SHALL be 1 exactly while in DONE; first assertion is WAIT_CYCLES+1 cycles after the i_mio_en rising edge is sampled.
REQ-019 In DONE, the block SHALL stay while i_mio_en=1 and return to IDLE the cycle after i_mio_en=0; no second access occurs without returning to IDLE.
REQ-020 If i_mio_en drops during BUSY, the access SHALL be aborted: go to IDLE, no RAM write, read-data register unchanged.
REQ-021 MAR SHALL load i_bus when i_ld_mar=1 and state is IDLE; i_ld_mar is ignored in BUSY/DONE.
REQ-022 MDR load priority SHALL be:
- If i_ld_mdr & i_mio_en & ~latched r_w & state==DONE: MDR <= read data.
- Else if i_ld_mdr & ~i_mio_en: MDR <= i_bus.
- Otherwise MDR holds.
REQ-023 Addresses SHALL alias: MAR bits above ADDR_W-1 are ignored for RAM.
REQ-024 i_ld_mdr and i_ld_mar asserted together in IDLE SHALL both take effect in the same cycle.

Reset
REQ-025 rst SHALL force: state IDLE, counter 0, MAR 0, MDR 0, read-data 0, o_ready 0, o_io_reg 0.
REQ-026 RAM contents SHALL NOT be reset.
REQ-027 rst during BUSY SHALL abort the access with no RAM write.

Configuration
REQ-028 The macro LC3_MEM_MMIO_EN SHALL control memory-mapped I/O.
REQ-029 With LC3_MEM_MMIO_EN defined:
- A read of MAR==16'hFE00 returns {12'h000, i_sw} sampled at execution.
- A write to MAR==16'hFE02 loads o_io_reg with MDR.
- Neither access touches RAM; latency is unchanged.
REQ-030 Without LC3_MEM_MMIO_EN, those addresses SHALL be ordinary aliased RAM and o_io_reg SHALL be constant 0.

Structure
REQ-031 A shared package lc3_pkg SHALL hold the FSM state encoding (IDLE/BUSY/DONE), the MMIO address constants (16'hFE00, 16'hFE02) and the word width (16).
REQ-032 The block SHALL contain one sub-module, lc3_sram (single-port, synchronous write, registered read, parameter ADDR_W); the FSM, MAR, MDR and MMIO logic stay in lc3_mem_ctrl.

Verification
REQ-033 Write/read-back: MAR=0x0005, MDR=0x1234, write request held; then read 0x0005 with i_ld_mdr in DONE -> o_ready after 4 cycles each, o_mdr=0x1234.
REQ-034 Alias: write 0xBEEF at MAR=0x0105 (ADDR_W=8), read MAR=0x0005 -> o_mdr=0xBEEF.
REQ-035 Abort: write request to 0x0010 (RAM=0x0000), drop i_mio_en after 1 cycle -> o_ready never asserts, later read of 0x0010 returns 0x0000.
REQ-036 Reset mid-BUSY: rst pulse during a write to 0x0020 -> all outputs 0, FSM IDLE, RAM[0x20] unchanged.
REQ-037 MMIO (macro defined): i_sw=4'hA, read 0xFE00 -> o_mdr=0x000A; write 0x5A5A to 0xFE02 -> o_io_reg=0x5A5A.
REQ-038 MAR protection: i_ld_mar=1 with i_bus=0x0077 during BUSY -> o_mar unchanged, access uses the original address.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared FSM encoding, word width and MMIO addresses for the LC-3 memory path.
package lc3_pkg;
   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] MMIO_IN_ADDR  = 16'hFE00;
   localparam logic [WORD_W-1:0] MMIO_OUT_ADDR = 16'hFE02;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/lc3_sram.sv
// lc3_sram: single-port RAM, synchronous write, registered read (read register resets, array does not).
module lc3_sram
   import lc3_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem [2**ADDR_W];
   logic [WORD_W-1:0] rdata_q;
   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;
   always_ff @(posedge clk or posedge rst)
      if (rst) rdata_q <= '0;
      else if (re) rdata_q <= mem[addr];
   assign rdata = rdata_q;
endmodule

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 MAR/MDR memory controller with fixed-latency handshake.
// Define LC3_MEM_MMIO_EN to map the switch input at FE00 and the output register at FE02.
module lc3_mem_ctrl
   import lc3_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_ld_mar,
   input  logic              i_ld_mdr,
   input  logic              i_mio_en,
   input  logic              i_r_w,
   input  logic [WORD_W-1:0] i_bus,
   input  logic [3:0]        i_sw,
   output logic [WORD_W-1:0] o_mdr,
   output logic [WORD_W-1:0] o_mar,
   output logic              o_ready,
   output logic [WORD_W-1:0] o_io_reg
);
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rw_q, rw_d, ready_q, ready_d, exec, mmio_rd, mmio_wr;
   logic [WORD_W-1:0] mar_q, mar_d, mdr_q, mdr_d, rd_data, sram_rdata;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      exec    = 1'b0;
      case (state_q)
         IDLE:
            if (i_mio_en) begin
               state_d = BUSY;
               cnt_d   = 4'(WAIT_CYCLES - 1);
               rw_d    = i_r_w;
            end
         BUSY:
            if (!i_mio_en) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = DONE;
               exec    = 1'b1;
            end else cnt_d = cnt_q - 4'd1;
         default:
            if (!i_mio_en) state_d = IDLE;
      endcase
      ready_d = state_d == DONE;
      mar_d   = (i_ld_mar && state_q == IDLE) ? i_bus : mar_q;
      mdr_d   = (i_ld_mdr && i_mio_en && !rw_q && state_q == DONE) ? rd_data :
                (i_ld_mdr && !i_mio_en) ? i_bus : mdr_q;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         ready_q <= 1'b0;
         mar_q   <= '0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         ready_q <= ready_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
      end

`ifdef LC3_MEM_MMIO_EN
   logic              sel_sw_q, sel_sw_d;
   logic [3:0]        sw_q, sw_d;
   logic [WORD_W-1:0] io_q, io_d;
   assign mmio_rd = mar_q == MMIO_IN_ADDR;
   assign mmio_wr = mar_q == MMIO_OUT_ADDR;
   // Read data comes from either the captured switches or the SRAM read register.
   always_comb begin
      sel_sw_d = (exec && !rw_q) ? mmio_rd : sel_sw_q;
      sw_d     = (exec && !rw_q && mmio_rd) ? i_sw : sw_q;
      io_d     = (exec && rw_q && mmio_wr) ? mdr_q : io_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sel_sw_q <= 1'b0;
         sw_q     <= '0;
         io_q     <= '0;
      end else begin
         sel_sw_q <= sel_sw_d;
         sw_q     <= sw_d;
         io_q     <= io_d;
      end
   assign rd_data  = sel_sw_q ? {12'h000, sw_q} : sram_rdata;
   assign o_io_reg = io_q;
`else
   logic unused_sw;
   assign unused_sw = ^i_sw;
   assign mmio_rd   = 1'b0;
   assign mmio_wr   = 1'b0;
   assign rd_data   = sram_rdata;
   assign o_io_reg  = '0;
`endif

   lc3_sram #(.ADDR_W(ADDR_W)) u_sram (
      .clk  (clk),
      .rst  (rst),
      .we   (exec && rw_q && !mmio_wr),
      .re   (exec && !rw_q && !mmio_rd),
      .addr (mar_q[ADDR_W-1:0]),
      .wdata(mdr_q),
      .rdata(sram_rdata)
   );

   assign o_mdr   = mdr_q;
   assign o_mar   = mar_q;
   assign o_ready = ready_q;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: directed checks of the LC-3 memory controller (ADDR_W=8, WAIT_CYCLES=3).
module tb_lc3_mem_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic        i_ld_mar = 1'b0, i_ld_mdr = 1'b0, i_mio_en = 1'b0, i_r_w = 1'b0;
   logic [15:0] i_bus = '0;
   logic [3:0]  i_sw = '0;
   logic [15:0] o_mdr, o_mar, o_io_reg;
   logic        o_ready;
   int          passed = 0, failed = 0, total = 0;

   lc3_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .i_ld_mar(i_ld_mar), .i_ld_mdr(i_ld_mdr), .i_mio_en(i_mio_en),
      .i_r_w(i_r_w), .i_bus(i_bus), .i_sw(i_sw), .o_mdr(o_mdr), .o_mar(o_mar),
      .o_ready(o_ready), .o_io_reg(o_io_reg)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_mar(input logic [15:0] v);
      i_ld_mar = 1'b1; i_bus = v;
      @(negedge clk);
      i_ld_mar = 1'b0;
   endtask

   task automatic set_mdr(input logic [15:0] v);
      i_ld_mdr = 1'b1; i_bus = v;
      @(negedge clk);
      i_ld_mdr = 1'b0;
   endtask

   // Full handshake; on reads, MDR is loaded in DONE.
   task automatic access(input logic rw, input string tag);
      int n = 0;
      i_mio_en = 1'b1; i_r_w = rw;
      do begin
         @(negedge clk);
         n++;
      end while (!o_ready && n < 12);
      chk({tag, "_latency"}, 16'(n), 16'd4);
      i_ld_mdr = !rw;
      @(negedge clk);
      i_ld_mdr = 1'b0;
      chk({tag, "_ready_hold"}, {15'd0, o_ready}, 16'd1);
      i_mio_en = 1'b0;
      @(negedge clk);
      chk({tag, "_ready_drop"}, {15'd0, o_ready}, 16'd0);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d, input string tag);
      set_mar(a);
      set_mdr(d);
      access(1'b1, tag);
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
      set_mar(a);
      set_mdr(16'h0000);
      access(1'b0, tag);
      chk({tag, "_data"}, o_mdr, exp);
   endtask

   initial begin
      logic seen;
      int   n;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mdr", o_mdr, 16'h0);
      chk("rst_mar", o_mar, 16'h0);
      chk("rst_ready", {15'd0, o_ready}, 16'h0);
      chk("rst_io", o_io_reg, 16'h0);
      rst = 1'b0;
      @(negedge clk);

      set_mar(16'h0005);
      chk("mar_load", o_mar, 16'h0005);
      set_mdr(16'h1234);
      chk("mdr_load", o_mdr, 16'h1234);
      access(1'b1, "wr5");
      rd(16'h0005, 16'h1234, "rd5");

      wr(16'h0105, 16'hBEEF, "wr105");
      rd(16'h0005, 16'hBEEF, "alias");

      wr(16'h0010, 16'h0000, "wr10");
      set_mdr(16'hFFFF);
      i_mio_en = 1'b1; i_r_w = 1'b1;
      @(negedge clk);
      i_mio_en = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen |= o_ready;
      end
      chk("abort_no_ready", {15'd0, seen}, 16'h0);
      rd(16'h0010, 16'h0000, "abort_rd");

      wr(16'h0077, 16'h0000, "wr77");
      set_mar(16'h0030);
      set_mdr(16'hCAFE);
      i_mio_en = 1'b1; i_r_w = 1'b1;
      @(negedge clk);
      i_ld_mar = 1'b1; i_bus = 16'h0077;
      @(negedge clk);
      i_ld_mar = 1'b0;
      chk("mar_protect", o_mar, 16'h0030);
      n = 0;
      while (!o_ready && n < 12) begin
         @(negedge clk);
         n++;
      end
      chk("protect_ready", {15'd0, o_ready}, 16'h1);
      i_mio_en = 1'b0;
      @(negedge clk);
      rd(16'h0030, 16'hCAFE, "protect_rd30");
      rd(16'h0077, 16'h0000, "protect_rd77");

      wr(16'h0020, 16'h1357, "wr20");
      set_mar(16'h0020);
      set_mdr(16'h2468);
      i_mio_en = 1'b1; i_r_w = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      i_mio_en = 1'b0;
      chk("mid_rst_mdr", o_mdr, 16'h0);
      chk("mid_rst_mar", o_mar, 16'h0);
      chk("mid_rst_ready", {15'd0, o_ready}, 16'h0);
      chk("mid_rst_io", o_io_reg, 16'h0);
      rst = 1'b0;
      @(negedge clk);
      rd(16'h0020, 16'h1357, "mid_rst_rd20");

      i_ld_mar = 1'b1; i_ld_mdr = 1'b1; i_bus = 16'h0042;
      @(negedge clk);
      i_ld_mar = 1'b0; i_ld_mdr = 1'b0;
      chk("both_mar", o_mar, 16'h0042);
      chk("both_mdr", o_mdr, 16'h0042);

      i_sw = 4'hA;
`ifdef LC3_MEM_MMIO_EN
      rd(16'hFE00, 16'h000A, "mmio_sw");
      wr(16'hFE02, 16'h5A5A, "mmio_io");
      chk("mmio_io_reg", o_io_reg, 16'h5A5A);
`else
      wr(16'h0000, 16'h0F0F, "wr00");
      wr(16'hFE02, 16'h5A5A, "fe02_ram");
      chk("no_mmio_io", o_io_reg, 16'h0);
      rd(16'hFE00, 16'h0F0F, "fe00_alias");
      rd(16'h0002, 16'h5A5A, "fe02_alias");
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
